// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the RAM arbiter: access sizes and FSM states.
package ram_arbiter_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_BAD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/ram_arbiter_lane_unit.sv
// Byte-lane steering for one RAM word: store merge, load extraction with
// sign/zero extension, and alignment checking.
module ram_lane_unit
    import ram_arbiter_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  size_e       size_i,
    input  logic [1:0]  offs_i,
    input  logic        uns_i,
    output logic [31:0] merged_o,
    output logic [31:0] load_o,
    output logic        misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  bit_offs;

    assign bit_offs = {offs_i, 3'b000};
    assign byte_sel = word_i[bit_offs +: 8];
    assign half_sel = offs_i[1] ? word_i[31:16] : word_i[15:0];

    always_comb begin
        merged_o   = word_i;
        load_o     = word_i;
        misalign_o = 1'b0;
        case (size_i)
            SZ_B: begin
                merged_o[bit_offs +: 8] = wdata_i[7:0];
                load_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                misalign_o = offs_i[0];
                if (offs_i[1]) merged_o[31:16] = wdata_i[15:0];
                else           merged_o[15:0]  = wdata_i[15:0];
                load_o = {{16{~uns_i & half_sel[15]}}, half_sel};
            end
            SZ_W: begin
                misalign_o = (offs_i != 2'b00);
                merged_o   = wdata_i;
            end
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter sharing a single-port 16x32 RAM between two requesters;
// sub-word stores are done as read-modify-write within the ACCESS cycle.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [1:0]        size0,
    input  logic [1:0]        size1,
    input  logic              uns0,
    input  logic              uns1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_e              state_q, state_d;
    logic                last_q;
    logic                id_q, id_d;
    logic                take;
    logic                we_q;
    size_e               size_q;
    logic                uns_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                ack0_q, ack1_q, err0_q, err1_q;
    logic [DATA_W-1:0]   rdata0_q, rdata1_q;
    logic [DATA_W-1:0]   merged, load_val;
    logic                misalign;
    logic                access;

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
        id_d    = id_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    take    = 1'b1;
                    state_d = S_ACCESS;
                    id_d    = (req0 && req1) ? ~last_q : req1;
                end
            end
            S_ACCESS: state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign access = (state_q == S_ACCESS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            if (take) begin
                id_q   <= id_d;
                we_q   <= id_d ? we1 : we0;
                addr_q <= id_d ? addr1 : addr0;
            end
            if (state_q == S_DONE) last_q <= id_q;
            ack0_q <= access && !id_q;
            ack1_q <= access && id_q;
            err0_q <= access && !id_q && misalign;
            err1_q <= access && id_q && misalign;
            // Failed or store accesses leave the requester's load result untouched.
            if (access && !we_q && !misalign) begin
                if (id_q) rdata1_q <= load_val;
                else      rdata0_q <= load_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            size_q  <= id_d ? size_e'(size1) : size_e'(size0);
            uns_q   <= id_d ? uns1 : uns0;
            wdata_q <= id_d ? wdata1 : wdata0;
        end
    end

    ram_lane_unit u_lane (
        .word_i     (ram_rdata),
        .wdata_i    (wdata_q),
        .size_i     (size_q),
        .offs_i     (addr_q[1:0]),
        .uns_i      (uns_q),
        .merged_o   (merged),
        .load_o     (load_val),
        .misalign_o (misalign)
    );

    // Pure state decode so an asynchronous reset kills the write at once.
    assign ram_we    = access && we_q && !misalign;
    assign ram_addr  = addr_q;
    assign ram_wdata = merged;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign err0      = err0_q;
    assign err1      = err1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural RAM plus a word-level
// reference model of loads, stores and alignment errors.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, uns0, uns1;
    logic [1:0]  size0, size1;
    logic [5:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1;
    logic        ack0, ack1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [5:0]  ram_addr;
    logic [31:0] ram_wdata, ram_rdata;
    logic        ram_we;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rd  [2];
    logic        pre_en = 1'b0;
    logic [3:0]  pre_idx = 4'd0;
    logic [31:0] pre_val = 32'd0;
    int          we_cnt = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .size0(size0), .size1(size1), .uns0(uns0), .uns1(uns1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata)
    );

    // Behavioural single-port RAM: combinational read, clocked write.
    assign ram_rdata = mem[ram_addr[5:2]];
    always @(posedge clk) begin
        if (ram_we)      mem[ram_addr[5:2]] <= ram_wdata;
        else if (pre_en) mem[pre_idx]       <= pre_val;
    end
    always @(negedge clk) if (ram_we) we_cnt <= we_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (time %0t, required finish)", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic is_bad(input logic [1:0] sz, input logic [5:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] w, input logic [5:0] a,
                                           input logic [1:0] sz, input logic uns);
        int sh;
        logic [31:0] v;
        sh = 8 * int'(a[1:0]);
        v  = w >> sh;
        if (sz == 2'b00) begin
            v = v & 32'h0000_00FF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = v & 32'h0000_FFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_store(input logic [31:0] w, input logic [5:0] a,
                                            input logic [1:0] sz, input logic [31:0] wd);
        int sh;
        logic [31:0] mask;
        sh   = 8 * int'(a[1:0]);
        mask = (sz == 2'b00) ? 32'hFF : (sz == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
        return (w & ~(mask << sh)) | ((wd & mask) << sh);
    endfunction

    task automatic model_txn(input bit id, input bit we, input logic [1:0] sz, input bit uns,
                             input logic [5:0] a, input logic [31:0] wd, output logic exp_err);
        exp_err = is_bad(sz, a);
        if (!exp_err) begin
            if (we) ref_mem[a[5:2]] = m_store(ref_mem[a[5:2]], a, sz, wd);
            else    exp_rd[id]      = m_load(ref_mem[a[5:2]], a, sz, uns);
        end
    endtask

    task automatic preset(input int idx, input logic [31:0] v);
        pre_en  = 1'b1;
        pre_idx = idx[3:0];
        pre_val = v;
        ref_mem[idx] = v;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    task automatic run_txn(input bit id, input bit we, input logic [1:0] sz, input bit uns,
                           input logic [5:0] a, input logic [31:0] wd,
                           output bit got, output logic er, output logic [31:0] rd,
                           output int lat, output bit other);
        got = 1'b0; er = 1'b0; rd = 32'd0; lat = 0; other = 1'b0;
        if (id) begin we1 = we; size1 = sz; uns1 = uns; addr1 = a; wdata1 = wd; req1 = 1'b1; end
        else    begin we0 = we; size0 = sz; uns0 = uns; addr0 = a; wdata0 = wd; req0 = 1'b1; end
        while (!got && lat < 12) begin
            @(posedge clk); #1;
            lat++;
            if (id ? ack0 : ack1) other = 1'b1;
            if (id ? ack1 : ack0) begin
                got = 1'b1;
                er  = id ? err1 : err0;
                rd  = id ? rdata1 : rdata0;
            end
        end
        @(posedge clk); #1;
        if (id) req1 = 1'b0; else req0 = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
    endtask

    task automatic test_reset();
        checks++;
        if ({ack0, ack1, err0, err1, ram_we} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b required 00000", {ack0, ack1, err0, err1, ram_we});
        end
        checks++;
        if (rdata0 !== 32'd0 || rdata1 !== 32'd0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h required 0/0", rdata0, rdata1);
        end
        checks++;
        if (ram_addr !== 6'd0) begin
            errors++; $display("FAIL reset_addr: got %h required 00", ram_addr);
        end
    endtask

    task automatic test_load_word();
        bit got, oth; logic er; logic [31:0] rd; int lat; logic xe;
        preset(3, 32'h1122_3344);
        run_txn(1'b0, 1'b0, 2'b10, 1'b0, 6'h0C, 32'd0, got, er, rd, lat, oth);
        model_txn(1'b0, 1'b0, 2'b10, 1'b0, 6'h0C, 32'd0, xe);
        checks++;
        if (!got || lat != 2) begin
            errors++; $display("FAIL load_word_latency: got ack=%0d after %0d cycles required 1 after 2", got, lat);
        end
        checks++;
        if (rd !== 32'h1122_3344 || rd !== exp_rd[0]) begin
            errors++; $display("FAIL load_word_data: got %h required %h", rd, 32'h1122_3344);
        end
        checks++;
        if (er !== xe) begin
            errors++; $display("FAIL load_word_err: got %b required %b", er, xe);
        end
    endtask

    task automatic test_store_byte();
        bit got, oth; logic er; logic [31:0] rd; int lat; logic xe;
        run_txn(1'b0, 1'b1, 2'b00, 1'b0, 6'h0D, 32'h0000_00AB, got, er, rd, lat, oth);
        model_txn(1'b0, 1'b1, 2'b00, 1'b0, 6'h0D, 32'h0000_00AB, xe);
        checks++;
        if (!got || er !== 1'b0) begin
            errors++; $display("FAIL store_byte_ack: got ack=%0d err=%b required ack=1 err=0", got, er);
        end
        checks++;
        if (mem[3] !== 32'h1122_AB44 || mem[3] !== ref_mem[3]) begin
            errors++; $display("FAIL store_byte_mem: got %h required %h", mem[3], 32'h1122_AB44);
        end
    endtask

    task automatic test_half_sign();
        bit got, oth; logic er; logic [31:0] rd; int lat; logic xe;
        preset(3, 32'h80FF_0000);
        run_txn(1'b0, 1'b0, 2'b01, 1'b0, 6'h0E, 32'd0, got, er, rd, lat, oth);
        model_txn(1'b0, 1'b0, 2'b01, 1'b0, 6'h0E, 32'd0, xe);
        checks++;
        if (!got || rd !== 32'hFFFF_80FF || rd !== exp_rd[0]) begin
            errors++; $display("FAIL half_signed: got %h required %h", rd, 32'hFFFF_80FF);
        end
        run_txn(1'b0, 1'b0, 2'b01, 1'b1, 6'h0E, 32'd0, got, er, rd, lat, oth);
        model_txn(1'b0, 1'b0, 2'b01, 1'b1, 6'h0E, 32'd0, xe);
        checks++;
        if (!got || rd !== 32'h0000_80FF || rd !== exp_rd[0]) begin
            errors++; $display("FAIL half_unsigned: got %h required %h", rd, 32'h0000_80FF);
        end
    endtask

    task automatic test_fairness();
        int order[$];
        int exp_order[4] = '{0, 1, 0, 1};
        int cyc;
        logic xe;
        do_reset();
        preset(0, 32'h0102_0384);
        preset(1, 32'h9A00_0000);
        we0 = 1'b0; size0 = 2'b10; uns0 = 1'b0; addr0 = 6'h00; wdata0 = 32'd0;
        we1 = 1'b0; size1 = 2'b00; uns1 = 1'b0; addr1 = 6'h07; wdata1 = 32'd0;
        model_txn(1'b0, 1'b0, 2'b10, 1'b0, 6'h00, 32'd0, xe);
        model_txn(1'b1, 1'b0, 2'b00, 1'b0, 6'h07, 32'd0, xe);
        req0 = 1'b1; req1 = 1'b1;
        cyc = 0;
        while (order.size() < 4 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            checks++;
            if (ack0 && ack1) begin
                errors++; $display("FAIL fair_dual_ack: got ack0=1 ack1=1 required at most one");
            end
            if (ack0) order.push_back(0);
            if (ack1) order.push_back(1);
        end
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        checks++;
        if (order.size() != 4) begin
            errors++; $display("FAIL fair_count: got %0d acks required 4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (order[i] != exp_order[i]) begin
                    errors++; $display("FAIL fair_order[%0d]: got %0d required %0d", i, order[i], exp_order[i]);
                end
            end
        end
        checks++;
        if (rdata0 !== exp_rd[0] || rdata1 !== exp_rd[1]) begin
            errors++; $display("FAIL fair_rdata: got %h/%h required %h/%h", rdata0, rdata1, exp_rd[0], exp_rd[1]);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_misaligned();
        bit got, oth; logic er; logic [31:0] rd; int lat; logic xe; int base;
        preset(1, 32'h5A5A_5A5A);
        base = we_cnt;
        run_txn(1'b0, 1'b1, 2'b10, 1'b0, 6'h05, 32'hDEAD_BEEF, got, er, rd, lat, oth);
        model_txn(1'b0, 1'b1, 2'b10, 1'b0, 6'h05, 32'hDEAD_BEEF, xe);
        checks++;
        if (!got || er !== 1'b1) begin
            errors++; $display("FAIL misalign_err: got ack=%0d err=%b required ack=1 err=1", got, er);
        end
        checks++;
        if (we_cnt != base) begin
            errors++; $display("FAIL misalign_we: got %0d write cycles required 0", we_cnt - base);
        end
        checks++;
        if (mem[1] !== 32'h5A5A_5A5A) begin
            errors++; $display("FAIL misalign_mem: got %h required %h", mem[1], 32'h5A5A_5A5A);
        end
        run_txn(1'b1, 1'b0, 2'b11, 1'b0, 6'h04, 32'd0, got, er, rd, lat, oth);
        model_txn(1'b1, 1'b0, 2'b11, 1'b0, 6'h04, 32'd0, xe);
        checks++;
        if (!got || er !== 1'b1 || rd !== exp_rd[1]) begin
            errors++; $display("FAIL bad_size_load: got err=%b rdata=%h required err=1 rdata=%h", er, rd, exp_rd[1]);
        end
    endtask

    task automatic test_reset_mid();
        bit got, oth; logic er; logic [31:0] rd; int lat; logic xe;
        preset(2, 32'hCAFE_F00D);
        we0 = 1'b1; size0 = 2'b10; uns0 = 1'b0; addr0 = 6'h08; wdata0 = 32'h1234_5678;
        req0 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ram_we !== 1'b1) begin
            errors++; $display("FAIL mid_we_before: got %b required 1", ram_we);
        end
        rst_n = 1'b0;
        req0  = 1'b0;
        #1;
        checks++;
        if (ram_we !== 1'b0 || ack0 !== 1'b0 || ram_addr !== 6'd0 || rdata0 !== 32'd0) begin
            errors++; $display("FAIL mid_reset_outs: got we=%b ack=%b addr=%h rdata=%h required 0/0/00/0",
                               ram_we, ack0, ram_addr, rdata0);
        end
        @(posedge clk); #1;
        checks++;
        if (mem[2] !== 32'hCAFE_F00D || ack0 !== 1'b0) begin
            errors++; $display("FAIL mid_reset_mem: got %h ack=%b required %h ack=0", mem[2], ack0, 32'hCAFE_F00D);
        end
        rst_n = 1'b1;
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        run_txn(1'b0, 1'b0, 2'b10, 1'b0, 6'h08, 32'd0, got, er, rd, lat, oth);
        model_txn(1'b0, 1'b0, 2'b10, 1'b0, 6'h08, 32'd0, xe);
        checks++;
        if (!got || lat != 2 || rd !== exp_rd[0]) begin
            errors++; $display("FAIL mid_recover: got ack=%0d lat=%0d rdata=%h required 1/2/%h", got, lat, rd, exp_rd[0]);
        end
    endtask

    task automatic test_random();
        bit got, oth, id, we, uns; logic er, xe; logic [31:0] rd, wd; int lat;
        logic [1:0] sz; logic [5:0] a;
        for (int n = 0; n < 40; n++) begin
            id  = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            sz  = 2'($urandom_range(0, 3));
            uns = 1'($urandom_range(0, 1));
            a   = 6'($urandom_range(0, 63));
            wd  = $urandom;
            run_txn(id, we, sz, uns, a, wd, got, er, rd, lat, oth);
            model_txn(id, we, sz, uns, a, wd, xe);
            checks++;
            if (!got || oth || er !== xe) begin
                errors++; $display("FAIL rand_ack[%0d]: got ack=%0d other=%0d err=%b required 1/0/%b", n, got, oth, er, xe);
            end
            checks++;
            if (rd !== exp_rd[id] || (id ? rdata0 : rdata1) !== exp_rd[!id]) begin
                errors++; $display("FAIL rand_rdata[%0d]: got %h required %h", n, rd, exp_rd[id]);
            end
            checks++;
            if (mem[a[5:2]] !== ref_mem[a[5:2]]) begin
                errors++; $display("FAIL rand_mem[%0d]: got %h required %h", n, mem[a[5:2]], ref_mem[a[5:2]]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        size0 = 2'b00; size1 = 2'b00; uns0 = 1'b0; uns1 = 1'b0;
        addr0 = 6'd0; addr1 = 6'd0; wdata0 = 32'd0; wdata1 = 32'd0;
        exp_rd[0] = 32'd0;
        exp_rd[1] = 32'd0;
        #1;
        for (int i = 0; i < 16; i++) preset(i, 32'd0);
        test_reset();
        rst_n = 1'b1;
        test_load_word();
        test_store_byte();
        test_half_sign();
        test_fairness();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
